// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame DMA controller.
package sobel_pkg;
  localparam int ADR_W = 22;
  localparam int DAT_W = 32;
  localparam int CNT_W = 17;
  localparam int unsigned IMG_BYTES_DEF = 32'h4B000;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH
  } state_e;

  // Byte address of word number cnt above base; wraps modulo 2^ADR_W.
  function automatic logic [ADR_W-1:0] word_adr(input logic [ADR_W-1:0] base,
                                                input logic [CNT_W-1:0] cnt);
    logic [ADR_W-1:0] off;
    off = ADR_W'({cnt, 2'b00});
    return base + off;
  endfunction
endpackage

// File: rtl/sobel_dma_ctrl_if.sv
// Memory bus plus pixel/result streams between the DMA controller and its peers.
interface sobel_dma_ctrl_if;
  import sobel_pkg::*;
  logic [ADR_W-1:0] mem_adr_o;
  logic [DAT_W-1:0] mem_dat_i;
  logic [DAT_W-1:0] mem_dat_o;
  logic             we;
  logic             ack_out;
  logic             readstart;
  logic             done;
  logic [7:0]       pix_o;
  logic             pix_valid;
  logic             pix_ready;
  logic [7:0]       res_i;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output mem_adr_o, mem_dat_o, we, ack_out, readstart, done,
    output pix_o, pix_valid, res_ready,
    input  mem_dat_i, pix_ready, res_i, res_valid
  );

  modport slave (
    input  mem_adr_o, mem_dat_o, we, ack_out, readstart, done,
    input  pix_o, pix_valid, res_ready,
    output mem_dat_i, pix_ready, res_i, res_valid
  );
endinterface

// File: rtl/sobel_byte_pack.sv
// 32-bit word <-> byte stream shifter. PACK=1 gathers bytes into a word,
// PACK=0 loads a word and emits it MSB byte first.
module sobel_byte_pack #(
  parameter bit PACK  = 1'b1,
  parameter int OUT_W = PACK ? 32 : 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic [31:0]      word_i,
  input  logic             step_i,
  input  logic [7:0]       byte_i,
  output logic [OUT_W-1:0] data_o,
  output logic [2:0]       cnt_o
);
  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;

  // Both directions shift left; the unpacker just has zeros fed in at byte_i.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (ld_i) begin
      word_d = word_i;
      cnt_d  = PACK ? 3'd0 : 3'd4;
    end else if (step_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = PACK ? cnt_q + 3'd1 : cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = word_q[31 -: OUT_W];
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/sobel_dma_ctrl.sv
// Frame DMA: streams source words to the Sobel core byte by byte and packs
// result bytes back into words, one memory transfer at a time.
module sobel_dma_ctrl import sobel_pkg::*; #(
  parameter int unsigned      IMG_BYTES = IMG_BYTES_DEF,
  parameter logic [ADR_W-1:0] RD_BASE   = '0,
  parameter logic [ADR_W-1:0] WR_BASE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  sobel_dma_ctrl_if.master  bus
);
  localparam logic [CNT_W-1:0] N_WORDS = CNT_W'(IMG_BYTES / 4);

  state_e           state_q, state_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic [2:0]  in_cnt, pk_cnt;
  logic [7:0]  in_byte;
  logic [31:0] pk_word;
  logic        pix_step, res_step, in_empty, pk_full;

  assign in_empty      = (in_cnt == 3'd0);
  assign pk_full       = (pk_cnt == 3'd4);
  assign bus.pix_valid = !in_empty;
  assign bus.pix_o     = in_byte;
  assign bus.res_ready = run_q && !pk_full;
  assign pix_step      = bus.pix_valid && bus.pix_ready;
  assign res_step      = bus.res_valid && bus.res_ready;

  sobel_byte_pack #(.PACK(1'b0)) u_unpack (
    .clk(clk), .rst(rst), .ld_i(state_q == RD_WAIT), .word_i(bus.mem_dat_i),
    .step_i(pix_step), .byte_i(8'h00), .data_o(in_byte), .cnt_o(in_cnt)
  );

  sobel_byte_pack #(.PACK(1'b1)) u_pack (
    .clk(clk), .rst(rst), .ld_i(state_q == WR_WAIT), .word_i(32'h0),
    .step_i(res_step), .byte_i(bus.res_i), .data_o(pk_word), .cnt_o(pk_cnt)
  );

  // IDLE with run_q set is the in-frame arbitration/wait point.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      IDLE: begin
        if (!run_q) begin
          if (start) begin
            state_d  = RD_REQ;
            run_d    = 1'b1;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
          end
        end else if (pk_full) begin
          state_d = WR_REQ;
        end else if (in_empty && rd_cnt_q < N_WORDS) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        state_d  = IDLE;
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
        if (wr_cnt_d == N_WORDS) begin
          state_d = FINISH;
          run_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Address/data are held through the WAIT state; only the strobe is single-cycle.
  always_comb begin
    bus.mem_adr_o = '0;
    bus.mem_dat_o = '0;
    bus.we        = 1'b0;
    bus.ack_out   = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      RD_REQ, RD_WAIT: begin
        bus.mem_adr_o = word_adr(RD_BASE, rd_cnt_q);
        bus.ack_out   = (state_q == RD_REQ);
      end
      WR_REQ, WR_WAIT: begin
        bus.mem_adr_o = word_adr(WR_BASE, wr_cnt_q);
        bus.mem_dat_o = pk_word;
        bus.we        = 1'b1;
        bus.done      = 1'b1;
        bus.ack_out   = (state_q == WR_REQ);
      end
      default: ;
    endcase
  end

  assign busy          = run_q;
  assign bus.readstart = run_q;
  assign frame_done    = (state_q == FINISH);
endmodule

// File: tb/tb_sobel_dma_ctrl.sv
// Self-checking bench: memory + loopback core models, scenario tasks, random data.
module tb_sobel_dma_ctrl;
  localparam int unsigned IMG = 16;
  localparam int NW = IMG / 4;
  localparam logic [21:0] RDB = 22'h3FFFF8;
  localparam logic [21:0] WRB = 22'h000040;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic busy, frame_done;

  sobel_dma_ctrl_if bus();

  sobel_dma_ctrl #(.IMG_BYTES(IMG), .RD_BASE(RDB), .WR_BASE(WRB)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done), .bus(bus)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  bit core_mode = 1'b0;
  logic man_pix_ready = 1'b0, man_res_valid = 1'b0;
  logic [7:0] man_res_i = 8'h00;
  logic lb_pix_ready = 1'b0, lb_res_valid = 1'b0;
  logic [7:0] lb_res_i = 8'h00;
  logic [31:0] rd_data = 32'h0;

  assign bus.pix_ready = core_mode ? lb_pix_ready : man_pix_ready;
  assign bus.res_valid = core_mode ? lb_res_valid : man_res_valid;
  assign bus.res_i     = core_mode ? lb_res_i     : man_res_i;
  assign bus.mem_dat_i = rd_data;

  logic [69:0] outs;
  assign outs = {busy, frame_done, bus.mem_adr_o, bus.mem_dat_o, bus.we, bus.ack_out,
                 bus.readstart, bus.done, bus.pix_o, bus.pix_valid, bus.res_ready};

  logic [31:0] src [logic [21:0]];
  logic [31:0] dst [logic [21:0]];
  logic [21:0] rd_log[$], wr_adr_log[$];
  logic [31:0] wr_dat_log[$];
  logic [7:0]  pix_log[$], lbq[$];
  int          pix_cyc[$];
  int cyc = 0, fd_cnt = 0, ack_cnt = 0, ack_viol = 0;
  logic ack_prev = 1'b0;
  logic [31:0] exp_w [NW];

  // Memory, transfer log and identity-loopback Sobel core.
  always @(posedge clk) begin
    cyc++;
    if (bus.ack_out) begin
      ack_cnt++;
      if (ack_prev) ack_viol++;
      if (!bus.we) begin
        rd_log.push_back(bus.mem_adr_o);
        if (bus.readstart)
          rd_data <= src.exists(bus.mem_adr_o) ? src[bus.mem_adr_o] : 32'hDEADBEEF;
      end else begin
        wr_adr_log.push_back(bus.mem_adr_o);
        wr_dat_log.push_back(bus.mem_dat_o);
        if (bus.readstart && bus.done) dst[bus.mem_adr_o] = bus.mem_dat_o;
      end
    end
    ack_prev = bus.ack_out;
    if (frame_done) fd_cnt++;
    if (bus.pix_valid && bus.pix_ready) begin
      pix_log.push_back(bus.pix_o);
      pix_cyc.push_back(cyc);
    end
    if (!rst || !core_mode) begin
      lbq.delete();
      lb_res_valid <= 1'b0;
      lb_res_i     <= 8'h00;
      lb_pix_ready <= 1'b0;
    end else begin
      if (bus.res_valid && bus.res_ready) void'(lbq.pop_front());
      if (bus.pix_valid && bus.pix_ready) lbq.push_back(bus.pix_o);
      lb_pix_ready <= ($urandom_range(3) != 0);
      lb_res_valid <= (lbq.size() != 0);
      lb_res_i     <= (lbq.size() != 0) ? lbq[0] : 8'h00;
    end
  end

  function automatic logic [21:0] exp_adr(input logic [21:0] base, input int k);
    longint a;
    a = (longint'(base) + 4 * k) % 64'd4194304;
    return a[21:0];
  endfunction

  function automatic logic [7:0] exp_pix(input int i);
    logic [31:0] w;
    w = exp_w[i / 4];
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; core_mode = 1'b0;
    man_pix_ready = 1'b0; man_res_valid = 1'b0; man_res_i = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_src;
    for (int k = 0; k < NW; k++) begin
      exp_w[k] = $urandom;
      src[exp_adr(RDB, k)] = exp_w[k];
    end
  endtask

  task automatic run_frame(input bit poke, output bit timed_out);
    int t;
    pulse_start;
    t = 0;
    while (!frame_done && t < 2000) begin
      if (poke && busy && $urandom_range(4) == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
      t++;
    end
    timed_out = (t >= 2000);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    int t, a0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    do_reset;
    load_src;
    pulse_start;
    t = 0;
    while (!bus.ack_out && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (bus.ack_out !== 1'b1) begin errs++; $display("FAIL reset_wait_read got ack=%b exp=1", bus.ack_out); end
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL reset_mid_read got=%h exp=0", outs); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    a0 = ack_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (ack_cnt - a0 !== 0) begin errs++; $display("FAIL reset_no_ack got=%0d acks exp=0", ack_cnt - a0); end
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_read_order;
    int rb, pb;
    do_reset;
    load_src;
    exp_w[0] = 32'h11223344;
    src[RDB] = exp_w[0];
    man_pix_ready = 1'b1;
    rb = rd_log.size(); pb = pix_log.size();
    pulse_start;
    checks++;
    if (busy !== 1'b1) begin errs++; $display("FAIL read_busy got=%b exp=1", busy); end
    checks++;
    if (bus.ack_out !== 1'b1 || bus.we !== 1'b0 || bus.mem_adr_o !== RDB) begin
      errs++; $display("FAIL read_first_req got ack=%b we=%b adr=%h exp 1 0 %h", bus.ack_out, bus.we, bus.mem_adr_o, RDB);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (rd_log.size() - rb !== NW) begin errs++; $display("FAIL read_count got=%0d exp=%0d", rd_log.size() - rb, NW); end
    for (int k = 0; k < NW && rb + k < rd_log.size(); k++) begin
      checks++;
      if (rd_log[rb + k] !== exp_adr(RDB, k)) begin
        errs++; $display("FAIL read_adr[%0d] got=%h exp=%h", k, rd_log[rb + k], exp_adr(RDB, k));
      end
    end
    checks++;
    if (pix_log.size() - pb !== 4 * NW) begin errs++; $display("FAIL pix_count got=%0d exp=%0d", pix_log.size() - pb, 4 * NW); end
    for (int i = 0; i < 4 * NW && pb + i < pix_log.size(); i++) begin
      checks++;
      if (pix_log[pb + i] !== exp_pix(i)) begin
        errs++; $display("FAIL pix_order[%0d] got=%h exp=%h", i, pix_log[pb + i], exp_pix(i));
      end
    end
    if (pix_cyc.size() >= pb + 4) begin
      checks++;
      if (pix_cyc[pb + 3] - pix_cyc[pb] !== 3) begin
        errs++; $display("FAIL pix_consecutive got span=%0d exp=3", pix_cyc[pb + 3] - pix_cyc[pb]);
      end
    end
  endtask

  task automatic test_write_pack;
    int t, wb;
    logic [7:0] bv [4];
    logic [21:0] a;
    logic [31:0] d;
    bv = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset;
    load_src;
    wb = wr_adr_log.size();
    pulse_start;
    for (int i = 0; i < 4; i++) begin
      man_res_valid = 1'b1;
      man_res_i = bv[i];
      t = 0;
      while (!bus.res_ready && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (bus.res_ready !== 1'b1) begin errs++; $display("FAIL wr_res_ready[%0d] got=%b exp=1", i, bus.res_ready); end
      @(negedge clk);
    end
    man_res_valid = 1'b0;
    checks++;
    if (bus.res_ready !== 1'b0) begin errs++; $display("FAIL wr_full_backpressure got=%b exp=0", bus.res_ready); end
    t = 0;
    while (!(bus.ack_out && bus.we) && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (bus.mem_adr_o !== WRB || bus.mem_dat_o !== 32'hAABBCCDD || bus.we !== 1'b1 ||
        bus.done !== 1'b1 || bus.ack_out !== 1'b1) begin
      errs++; $display("FAIL wr_req got adr=%h dat=%h we=%b done=%b ack=%b exp %h AABBCCDD 1 1 1",
                       bus.mem_adr_o, bus.mem_dat_o, bus.we, bus.done, bus.ack_out, WRB);
    end
    a = bus.mem_adr_o; d = bus.mem_dat_o;
    @(negedge clk);
    checks++;
    if (bus.mem_adr_o !== WRB || bus.mem_dat_o !== 32'hAABBCCDD || bus.we !== 1'b1 ||
        bus.done !== 1'b1 || bus.ack_out !== 1'b0) begin
      errs++; $display("FAIL wr_hold got adr=%h dat=%h we=%b done=%b ack=%b exp %h AABBCCDD 1 1 0 (prev %h %h)",
                       bus.mem_adr_o, bus.mem_dat_o, bus.we, bus.done, bus.ack_out, WRB, a, d);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_adr_log.size() - wb !== 1) begin errs++; $display("FAIL wr_count got=%0d exp=1", wr_adr_log.size() - wb); end
    checks++;
    if (bus.res_ready !== 1'b1) begin errs++; $display("FAIL wr_packer_cleared got res_ready=%b exp=1", bus.res_ready); end
  endtask

  task automatic test_backpressure;
    int t, rb, pb;
    logic [7:0] first;
    do_reset;
    load_src;
    rb = rd_log.size(); pb = pix_log.size();
    pulse_start;
    t = 0;
    while (!bus.pix_valid && t < 50) begin @(negedge clk); t++; end
    first = bus.pix_o;
    checks++;
    if (first !== exp_pix(0)) begin errs++; $display("FAIL bp_first got=%h exp=%h", first, exp_pix(0)); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus.pix_o !== exp_pix(0) || bus.pix_valid !== 1'b1) begin
        errs++; $display("FAIL bp_stable[%0d] got pix=%h valid=%b exp %h 1", c, bus.pix_o, bus.pix_valid, exp_pix(0));
      end
    end
    checks++;
    if (rd_log.size() - rb !== 1) begin errs++; $display("FAIL bp_reads got=%0d exp=1", rd_log.size() - rb); end
    man_pix_ready = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (pix_log.size() - pb !== 4 * NW) begin errs++; $display("FAIL bp_drain got=%0d exp=%0d", pix_log.size() - pb, 4 * NW); end
    if (pix_log.size() >= pb + 2) begin
      checks++;
      if (pix_log[pb + 1] !== exp_pix(1)) begin errs++; $display("FAIL bp_second got=%h exp=%h", pix_log[pb + 1], exp_pix(1)); end
    end
  endtask

  task automatic check_frame(input string tag, input bit to, input int rb, input int wb, input int fb, input int vb);
    logic [31:0] got;
    checks++;
    if (to) begin errs++; $display("FAIL %s_timeout got no frame_done exp frame_done", tag); end
    checks++;
    if (rd_log.size() - rb !== NW || wr_adr_log.size() - wb !== NW) begin
      errs++; $display("FAIL %s_counts got rd=%0d wr=%0d exp %0d %0d", tag, rd_log.size() - rb, wr_adr_log.size() - wb, NW, NW);
    end
    for (int k = 0; k < NW && wb + k < wr_adr_log.size(); k++) begin
      checks++;
      if (wr_adr_log[wb + k] !== exp_adr(WRB, k) || wr_dat_log[wb + k] !== exp_w[k]) begin
        errs++; $display("FAIL %s_write[%0d] got %h:%h exp %h:%h", tag, k, wr_adr_log[wb + k], wr_dat_log[wb + k], exp_adr(WRB, k), exp_w[k]);
      end
    end
    for (int k = 0; k < NW; k++) begin
      got = dst.exists(exp_adr(WRB, k)) ? dst[exp_adr(WRB, k)] : 32'hx;
      checks++;
      if (got !== exp_w[k]) begin errs++; $display("FAIL %s_dst[%0d] got=%h exp=%h", tag, k, got, exp_w[k]); end
    end
    checks++;
    if (fd_cnt - fb !== 1) begin errs++; $display("FAIL %s_frame_done got=%0d pulses exp=1", tag, fd_cnt - fb); end
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL %s_busy_after got=%b exp=0", tag, busy); end
    checks++;
    if (ack_viol - vb !== 0) begin errs++; $display("FAIL %s_ack_spacing got=%0d back-to-back acks exp=0", tag, ack_viol - vb); end
  endtask

  task automatic test_full_frame;
    bit to;
    int rb, wb, fb, vb;
    do_reset;
    load_src;
    core_mode = 1'b1;
    rb = rd_log.size(); wb = wr_adr_log.size(); fb = fd_cnt; vb = ack_viol;
    run_frame(1'b0, to);
    check_frame("frame", to, rb, wb, fb, vb);
    for (int k = 0; k < NW && rb + k < rd_log.size(); k++) begin
      checks++;
      if (rd_log[rb + k] !== exp_adr(RDB, k)) begin
        errs++; $display("FAIL frame_rd_adr[%0d] got=%h exp=%h", k, rd_log[rb + k], exp_adr(RDB, k));
      end
    end
  endtask

  task automatic test_back_to_back;
    bit to;
    int rb, wb, fb, vb;
    load_src;
    rb = rd_log.size(); wb = wr_adr_log.size(); fb = fd_cnt; vb = ack_viol;
    run_frame(1'b0, to);
    check_frame("b2b", to, rb, wb, fb, vb);
  endtask

  task automatic test_start_while_busy;
    bit to;
    int rb, wb, fb, vb;
    load_src;
    rb = rd_log.size(); wb = wr_adr_log.size(); fb = fd_cnt; vb = ack_viol;
    run_frame(1'b1, to);
    check_frame("busy_start", to, rb, wb, fb, vb);
  endtask

  initial begin
    test_reset;
    test_read_order;
    test_write_pack;
    test_backpressure;
    test_full_frame;
    test_back_to_back;
    test_start_while_busy;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sobel_dma_ctrl.md
SOBEL_DMA_CTRL -- requirements
Module: sobel_dma_ctrl

Interface
REQ-001 Parameter IMG_BYTES, default 'h4B000, frame size in bytes (640x480x8bit); SHALL be a multiple of 4.
REQ-002 Parameter RD_BASE, default 22'h0, byte address of first source word.
REQ-003 Parameter WR_BASE, default 22'h0, byte address of first result word (result memory is a separate array).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse; begins a frame when idle.
REQ-007 busy  out  1  high from the cycle after an accepted start until frame_done.
REQ-008 frame_done  out  1  one-cycle pulse after the last result word is written.
REQ-009 mem_adr_o  out  22  byte address of the current word transfer.
REQ-010 mem_dat_i  in  32  read data; mem[adr] in bits 31:24.
REQ-011 mem_dat_o  out  32  write data, same byte order.
REQ-012 we  out  1  0 = read transfer, 1 = write transfer.
REQ-013 ack_out  out  1  one-cycle transfer strobe to memory.
REQ-014 readstart  out  1  high while busy; memory services strobes only when set.
REQ-015 done  out  1  write data valid qualifier; high with ack_out on writes.
REQ-016 pix_o  out  8  source pixel to Sobel core.
REQ-017 pix_valid / pix_ready  out / in  1 each  pixel handshake; transfer when both high.
REQ-018 res_i  in  8  result pixel from Sobel core.
REQ-019 res_valid / res_ready  in / out  1 each  result handshake; transfer when both high.

Function
REQ-020 FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH; IDLE -> RD_REQ on start.
REQ-021 Read: in RD_REQ drive mem_adr_o = RD_BASE + 4*rd_cnt, we=0, ack_out=1 for one cycle; in RD_WAIT (exactly one cycle later) capture mem_dat_i into 4-byte input buffer, rd_cnt+1.
REQ-022 Input buffer emits bytes 31:24, 23:16, 15:8, 7:0 in that order; pix_o/pix_valid stable until accepted.
REQ-023 Result packer shifts accepted res_i into a 32-bit word, first byte landing in 31:24; res_ready low while packer holds 4 unsent bytes.
REQ-024 Write: in WR_REQ drive mem_adr_o = WR_BASE + 4*wr_cnt, mem_dat_o = packed word, we=1, done=1, ack_out=1 for one cycle; hold mem_adr_o, mem_dat_o, we, done through WR_WAIT (one cycle); wr_cnt+1, packer cleared.
REQ-025 Arbitration from any non-transfer state: write has priority when packer full; else read when input buffer empty and rd_cnt < IMG_BYTES/4; else wait.
REQ-026 Read and write transfers never overlap; at most one ack_out per two cycles.
REQ-027 When wr_cnt reaches IMG_BYTES/4: FINISH for one cycle, frame_done=1, busy=0, return to IDLE.
REQ-028 start while busy SHALL be ignored.
REQ-029 Pixel stream and result stream SHALL proceed concurrently with memory transfers (buffering decouples them).
REQ-030 Counters 17 bits wide; address arithmetic modulo 2^22, no saturation.

Reset
REQ-031 Asserted rst (low) SHALL immediately force IDLE, clear counters, buffers, packer; all outputs 0 (mem_adr_o, mem_dat_o, pix_o zero; all strobes, valids, readys low).
REQ-032 Reset mid-transfer abandons the frame; no ack_out after reset release until a new start.

Structure
REQ-033 Shared package sobel_pkg holds FSM state enumeration, IMG_BYTES default, address/data width constants.
REQ-034 One sub-module natural: sobel_byte_pack (32-bit word <-> byte stream, both directions via parameter), instanced twice.

Verification
REQ-035 Reset: rst low mid-read -> all outputs 0 same cycle; after release, no ack_out until start.
REQ-036 Read order: mem[0..3]=11,22,33,44, start, pix_ready=1 -> ack_out with adr 0, we 0, then pix_o 11,22,33,44 consecutive.
REQ-037 Write pack: res_i AA,BB,CC,DD -> ack_out with we=1, done=1, adr WR_BASE, mem_dat_o AABBCCDD held two cycles.
REQ-038 Backpressure: pix_ready low 20 cycles -> pix_o stable, no further read strobe.
REQ-039 Full frame, IMG_BYTES=16, identity loopback -> 4 reads, 4 writes, result memory equals source, one frame_done pulse, busy low afterward.
REQ-040 start pulsed while busy -> counters unchanged, single frame_done.
